// File: rtl/assoc_icache_if.sv
// Fetch-side and refill-side signals of the associative instruction cache.
// A refill word transfers on any cycle where iREN && !iwait; iaddr/iREN stay stable while stalled.
interface assoc_icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        busy;
  logic [1:0]  state_dbg;

  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr, busy, state_dbg
  );

  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr, busy, state_dbg
  );
endinterface

// File: rtl/assoc_icache.sv
// Set-associative (1 or 2 way) instruction cache with LRU replacement,
// multi-word block refill from the memory controller and a flush command.
module assoc_icache #(
  parameter int SETS        = 8,
  parameter int BLOCK_WORDS = 2,
  parameter int WAYS        = 2
) (
  input  logic          CLK,
  input  logic          RST,
  assoc_icache_if.slave bus
);
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int CNT_W = (OFF_W < 1) ? 1 : OFF_W;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, FLUSH = 2'd2} state_t;
  state_t r_state, w_next;

  logic             r_valid [WAYS][SETS];
  logic [TAG_W-1:0] r_tag   [WAYS][SETS];
  logic [31:0]      r_data  [WAYS][SETS][BLOCK_WORDS];
  logic             r_lru   [SETS];

  logic [TAG_W-1:0] r_miss_tag;
  logic [IDX_W-1:0] r_miss_idx;
  logic             r_victim;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend;

  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_idx;
  logic [CNT_W-1:0] w_woff;
  logic             w_any_hit;
  logic             w_hit_way;
  logic [31:0]      w_hit_data;
  logic             w_ihit;
  logic             w_victim;
  logic             w_accept;
  logic             w_last;
  logic             w_start_fill;

  assign w_tag  = bus.imemaddr[31 -: TAG_W];
  assign w_idx  = bus.imemaddr[2+OFF_W +: IDX_W];
  assign w_woff = (OFF_W == 0) ? '0 : bus.imemaddr[2 +: CNT_W];

  always_comb begin
    w_any_hit  = 1'b0;
    w_hit_way  = 1'b0;
    w_hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_any_hit && r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
        w_any_hit  = 1'b1;
        w_hit_way  = w[0];
        w_hit_data = r_data[w][w_idx][w_woff];
      end
    end
  end

  // Lowest invalid way first; only a fully occupied set consults the LRU bit.
  always_comb begin
    w_victim = 1'b0;
    if (WAYS == 2) begin
      if (!r_valid[0][w_idx])             w_victim = 1'b0;
      else if (!r_valid[WAYS-1][w_idx])   w_victim = 1'b1;
      else                                w_victim = r_lru[w_idx];
    end
  end

  assign w_ihit       = bus.imemREN && (r_state == IDLE) && w_any_hit;
  assign w_accept     = (r_state == FILL) && !bus.iwait;
  assign w_last       = (r_cnt == LAST_CNT);
  assign w_start_fill = !bus.flush && bus.imemREN && !w_any_hit;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.flush)        w_next = FLUSH;
        else if (w_start_fill) w_next = FILL;
      end
      FILL: begin
        if (w_accept && w_last) w_next = (r_pend || bus.flush) ? FLUSH : IDLE;
      end
      FLUSH:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_miss_tag <= '0;
      r_miss_idx <= '0;
      r_victim   <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        r_lru[s] <= 1'b0;
        for (int w = 0; w < WAYS; w++) begin
          r_valid[w][s] <= 1'b0;
          r_tag[w][s]   <= '0;
        end
      end
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_ihit && (WAYS == 2)) r_lru[w_idx] <= ~w_hit_way;
          if (w_start_fill) begin
            r_miss_tag <= w_tag;
            r_miss_idx <= w_idx;
            r_victim   <= w_victim;
            r_cnt      <= '0;
          end
        end
        FILL: begin
          if (bus.flush) r_pend <= 1'b1;
          if (w_accept) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            // The line only becomes visible once its final word has landed.
            if (w_last) begin
              r_valid[r_victim][r_miss_idx] <= 1'b1;
              r_tag[r_victim][r_miss_idx]   <= r_miss_tag;
              if (WAYS == 2) r_lru[r_miss_idx] <= ~r_victim;
            end
          end
        end
        FLUSH: begin
          r_pend <= 1'b0;
          for (int s = 0; s < SETS; s++) begin
            r_lru[s] <= 1'b0;
            for (int w = 0; w < WAYS; w++) r_valid[w][s] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_accept) r_data[r_victim][r_miss_idx][r_cnt] <= bus.iload;
  end

  assign bus.ihit      = w_ihit;
  assign bus.imemload  = w_ihit ? w_hit_data : '0;
  assign bus.iREN      = (r_state == FILL);
  assign bus.iaddr     = (r_state == FILL)
                         ? ({r_miss_tag, r_miss_idx, {(OFF_W+2){1'b0}}} | (32'(r_cnt) << 2))
                         : '0;
  assign bus.busy      = (r_state != IDLE);
  assign bus.state_dbg = r_state;
endmodule

// File: tb/tb_assoc_icache.sv
// Bench for assoc_icache: default config (8 sets, 2 words, 2 ways) checked against a
// recency-list model, plus a 4-set / 4-word / 1-way instance for the parametric cases.
module tb_assoc_icache;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  assoc_icache_if b0();
  assoc_icache_if b1();

  assoc_icache u_dut0 (.CLK(CLK), .RST(RST), .bus(b0.slave));
  assoc_icache #(.SETS(4), .BLOCK_WORDS(4), .WAYS(1)) u_dut1 (.CLK(CLK), .RST(RST), .bus(b1.slave));

  // Bench memory: word at byte address A is A ^ 32'hA5A50000.
  assign b0.iload = b0.iaddr ^ 32'hA5A50000;
  assign b1.iload = b1.iaddr ^ 32'hA5A50000;

  int checks   = 0;
  int failures = 0;

  // Model of the default config: per set, resident block numbers ordered LRU -> MRU.
  logic [28:0] m_blk [8][2];
  int          m_n   [8];

  function automatic void model_flush();
    for (int s = 0; s < 8; s++) m_n[s] = 0;
  endfunction

  function automatic bit model_access(input logic [31:0] a);
    logic [28:0] blk;
    int s;
    blk = a[31:3];
    s   = int'(a[31:3] % 8);
    for (int i = 0; i < m_n[s]; i++) begin
      if (m_blk[s][i] == blk) begin
        if (m_n[s] == 2 && i == 0) begin
          m_blk[s][0] = m_blk[s][1];
          m_blk[s][1] = blk;
        end
        return 1'b1;
      end
    end
    if (m_n[s] == 2) begin
      m_blk[s][0] = m_blk[s][1];
      m_blk[s][1] = blk;
    end else begin
      m_blk[s][m_n[s]] = blk;
      m_n[s] = m_n[s] + 1;
    end
    return 1'b0;
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    b0.imemREN = 1'b0; b0.imemaddr = '0; b0.flush = 1'b0; b0.iwait = 1'b0;
    b1.imemREN = 1'b0; b1.imemaddr = '0; b1.flush = 1'b0; b1.iwait = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    model_flush();
  endtask

  // stall < 0 picks a random 0..2 stall cycles per refill word.
  task automatic fetch0(input logic [31:0] a, input int stall, output bit hit, output int fill_cyc);
    bit exp_hit;
    logic [31:0] base;
    exp_hit  = model_access(a);
    base     = {a[31:3], 3'b000};
    fill_cyc = 0;
    @(negedge CLK);
    b0.imemREN = 1'b1; b0.imemaddr = a; b0.iwait = 1'b0;
    #1;
    hit = b0.ihit;
    checks++;
    if (b0.ihit !== exp_hit) begin
      failures++;
      $display("FAIL fetch0_hit addr=%h: got %b expected %b", a, b0.ihit, exp_hit);
    end
    if (!exp_hit) begin
      for (int k = 0; k < 2; k++) begin
        int st;
        st = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
        for (int j = 0; j <= st; j++) begin
          @(negedge CLK);
          b0.iwait = (j < st);
          #1;
          fill_cyc++;
          checks++;
          if (b0.iREN !== 1'b1 || b0.iaddr !== base + 32'(4 * k) || b0.busy !== 1'b1 || b0.ihit !== 1'b0) begin
            failures++;
            $display("FAIL fill_req addr=%h word=%0d: got iREN=%b iaddr=%h busy=%b expected iREN=1 iaddr=%h busy=1",
                     a, k, b0.iREN, b0.iaddr, b0.busy, base + 32'(4 * k));
          end
        end
      end
      @(negedge CLK);
      b0.iwait = 1'b0;
      #1;
    end
    checks++;
    if (b0.ihit !== 1'b1 || b0.imemload !== (a ^ 32'hA5A50000) || b0.iREN !== 1'b0) begin
      failures++;
      $display("FAIL fetch0_data addr=%h: got ihit=%b data=%h iREN=%b expected ihit=1 data=%h iREN=0",
               a, b0.ihit, b0.imemload, b0.iREN, a ^ 32'hA5A50000);
    end
  endtask

  task automatic fetch1(input logic [31:0] a, input bit exp_hit, output bit hit);
    logic [31:0] base;
    base = {a[31:4], 4'h0};
    @(negedge CLK);
    b1.imemREN = 1'b1; b1.imemaddr = a; b1.iwait = 1'b0;
    #1;
    hit = b1.ihit;
    checks++;
    if (b1.ihit !== exp_hit) begin
      failures++;
      $display("FAIL fetch1_hit addr=%h: got %b expected %b", a, b1.ihit, exp_hit);
    end
    if (!exp_hit) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge CLK);
        #1;
        checks++;
        if (b1.iREN !== 1'b1 || b1.iaddr !== base + 32'(4 * k)) begin
          failures++;
          $display("FAIL fill1_req addr=%h word=%0d: got iREN=%b iaddr=%h expected iREN=1 iaddr=%h",
                   a, k, b1.iREN, b1.iaddr, base + 32'(4 * k));
        end
      end
      @(negedge CLK);
      #1;
    end
    checks++;
    if (b1.ihit !== 1'b1 || b1.imemload !== (a ^ 32'hA5A50000) || b1.iREN !== 1'b0) begin
      failures++;
      $display("FAIL fetch1_data addr=%h: got ihit=%b data=%h iREN=%b expected ihit=1 data=%h iREN=0",
               a, b1.ihit, b1.imemload, b1.iREN, a ^ 32'hA5A50000);
    end
  endtask

  task automatic pulse_flush0();
    @(negedge CLK);
    b0.imemREN = 1'b0; b0.flush = 1'b1;
    #1;
    checks++;
    if (b0.busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_pre_busy: got %b expected 0", b0.busy);
    end
    @(negedge CLK);
    b0.flush = 1'b0; b0.imemREN = 1'b1; b0.imemaddr = 32'h0;
    #1;
    checks++;
    if (b0.busy !== 1'b1 || b0.iREN !== 1'b0 || b0.ihit !== 1'b0) begin
      failures++;
      $display("FAIL flush_cycle: got busy=%b iREN=%b ihit=%b expected busy=1 iREN=0 ihit=0", b0.busy, b0.iREN, b0.ihit);
    end
    @(negedge CLK);
    b0.imemREN = 1'b0;
    #1;
    checks++;
    if (b0.busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_done_busy: got %b expected 0", b0.busy);
    end
    model_flush();
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b1;
    b0.imemREN = 1'b1; b0.imemaddr = '0; b0.flush = 1'b0; b0.iwait = 1'b0;
    b1.imemREN = 1'b1; b1.imemaddr = '0; b1.flush = 1'b0; b1.iwait = 1'b0;
    #1;
    checks++;
    if (b0.ihit !== 1'b0 || b0.iREN !== 1'b0 || b0.iaddr !== 32'h0 || b0.busy !== 1'b0 || b0.imemload !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs0: got ihit=%b iREN=%b iaddr=%h busy=%b load=%h expected all 0",
               b0.ihit, b0.iREN, b0.iaddr, b0.busy, b0.imemload);
    end
    checks++;
    if (b1.ihit !== 1'b0 || b1.iREN !== 1'b0 || b1.iaddr !== 32'h0 || b1.busy !== 1'b0 || b1.imemload !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs1: got ihit=%b iREN=%b iaddr=%h busy=%b load=%h expected all 0",
               b1.ihit, b1.iREN, b1.iaddr, b1.busy, b1.imemload);
    end
    do_reset();
  endtask

  task automatic test_cold_miss();
    bit h; int fc;
    do_reset();
    fetch0(32'h04, 0, h, fc);
    checks++;
    if (h !== 1'b0 || fc != 2) begin
      failures++;
      $display("FAIL cold_miss: got hit=%b refill_cycles=%0d expected hit=0 refill_cycles=2", h, fc);
    end
    fetch0(32'h00, 0, h, fc);
    checks++;
    if (h !== 1'b1) begin
      failures++;
      $display("FAIL cold_neighbour_hit: got %b expected 1", h);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] addrs [8] = '{32'h000, 32'h040, 32'h000, 32'h040, 32'h000, 32'h080, 32'h000, 32'h040};
    bit          exps  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    bit h; int fc;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      fetch0(addrs[i], 0, h, fc);
      checks++;
      if (h !== exps[i]) begin
        failures++;
        $display("FAIL conflict_step%0d addr=%h: got hit=%b expected %b", i, addrs[i], h, exps[i]);
      end
    end
  endtask

  task automatic test_stall();
    bit h; int fc;
    do_reset();
    fetch0(32'h10, 3, h, fc);
    checks++;
    if (h !== 1'b0 || fc != 8) begin
      failures++;
      $display("FAIL stall_fill: got hit=%b refill_cycles=%0d expected hit=0 refill_cycles=8", h, fc);
    end
  endtask

  task automatic test_flush();
    bit h; int fc;
    do_reset();
    fetch0(32'h00, 0, h, fc);
    fetch0(32'h20, 0, h, fc);
    pulse_flush0();
    fetch0(32'h00, 0, h, fc);
    checks++;
    if (h !== 1'b0) begin
      failures++;
      $display("FAIL flush_miss_00: got hit=%b expected 0", h);
    end
    fetch0(32'h20, 0, h, fc);
    checks++;
    if (h !== 1'b0) begin
      failures++;
      $display("FAIL flush_miss_20: got hit=%b expected 0", h);
    end
  endtask

  task automatic test_flush_mid_fill();
    bit h; int fc;
    do_reset();
    @(negedge CLK);
    b0.imemREN = 1'b1; b0.imemaddr = 32'h30;
    @(negedge CLK);
    b0.flush = 1'b1;
    #1;
    checks++;
    if (b0.iREN !== 1'b1 || b0.iaddr !== 32'h30) begin
      failures++;
      $display("FAIL midflush_word0: got iREN=%b iaddr=%h expected iREN=1 iaddr=00000030", b0.iREN, b0.iaddr);
    end
    @(negedge CLK);
    b0.flush = 1'b0;
    #1;
    checks++;
    if (b0.iREN !== 1'b1 || b0.iaddr !== 32'h34) begin
      failures++;
      $display("FAIL midflush_word1: got iREN=%b iaddr=%h expected iREN=1 iaddr=00000034", b0.iREN, b0.iaddr);
    end
    @(negedge CLK);
    #1;
    checks++;
    if (b0.busy !== 1'b1 || b0.iREN !== 1'b0 || b0.ihit !== 1'b0) begin
      failures++;
      $display("FAIL midflush_flush_cycle: got busy=%b iREN=%b ihit=%b expected busy=1 iREN=0 ihit=0",
               b0.busy, b0.iREN, b0.ihit);
    end
    @(negedge CLK);
    b0.imemREN = 1'b0;
    model_flush();
    fetch0(32'h30, 0, h, fc);
    checks++;
    if (h !== 1'b0) begin
      failures++;
      $display("FAIL midflush_line_gone: got hit=%b expected 0", h);
    end
  endtask

  task automatic test_reset_mid_fill();
    bit h; int fc;
    do_reset();
    @(negedge CLK);
    b0.imemREN = 1'b1; b0.imemaddr = 32'h00;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    checks++;
    if (b0.iREN !== 1'b1 || b0.iaddr !== 32'h04) begin
      failures++;
      $display("FAIL rstfill_second_word: got iREN=%b iaddr=%h expected iREN=1 iaddr=00000004", b0.iREN, b0.iaddr);
    end
    RST = 1'b1;
    #1;
    checks++;
    if (b0.iREN !== 1'b0 || b0.busy !== 1'b0 || b0.iaddr !== 32'h0) begin
      failures++;
      $display("FAIL rstfill_async_drop: got iREN=%b busy=%b iaddr=%h expected 0 0 00000000", b0.iREN, b0.busy, b0.iaddr);
    end
    b0.imemREN = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    model_flush();
    fetch0(32'h00, 0, h, fc);
    checks++;
    if (h !== 1'b0) begin
      failures++;
      $display("FAIL rstfill_line_invalid: got hit=%b expected 0", h);
    end
  endtask

  task automatic test_random();
    bit h; int fc;
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        pulse_flush0();
      end else begin
        a = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 3)) << 3) | (32'($urandom_range(0, 1)) << 2);
        fetch0(a, -1, h, fc);
      end
    end
  endtask

  task automatic test_param();
    bit h;
    do_reset();
    fetch1(32'h08, 1'b0, h);
    fetch1(32'h0C, 1'b1, h);
    fetch1(32'h48, 1'b0, h);
    fetch1(32'h08, 1'b0, h);
    checks++;
    if (h !== 1'b0) begin
      failures++;
      $display("FAIL param_evicted: got hit=%b expected 0", h);
    end
  endtask

  initial begin
    RST = 1'b1;
    b0.imemREN = 1'b0; b0.imemaddr = '0; b0.flush = 1'b0; b0.iwait = 1'b0;
    b1.imemREN = 1'b0; b1.imemaddr = '0; b1.flush = 1'b0; b1.iwait = 1'b0;
    model_flush();
    test_reset();
    test_cold_miss();
    test_conflict();
    test_stall();
    test_flush();
    test_flush_mid_fill();
    test_reset_mid_fill();
    test_random();
    test_param();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/assoc_icache.md
Name: assoc_icache

Overview:
- Parametrised instruction cache sitting between the fetch stage (datapath side) and the memory controller (ccif instruction channel).
- Successor to the single-word direct-mapped icache: configurable set count, words per block and associativity (1 or 2 ways), with LRU replacement.
- Adds multi-word block refill and a flush command.

Parameters:
SETS, 8, number of sets; power of two, at least 2.
BLOCK_WORDS, 2, 32-bit words per block; power of two, at least 1.
WAYS, 2, associativity; legal values 1 or 2 only.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset; one clock; reset is asynchronous and active-high.
- imemREN  input  1  fetch request from datapath.
- imemaddr  input  32  fetch byte address, word aligned.
- flush  input  1  invalidate all lines; single-cycle pulse.
- ihit  output  1  fetch data valid this cycle.
- imemload  output  32  instruction word.
- iREN  output  1  refill read request to memory controller.
- iaddr  output  32  refill word address.
- iwait  input  1  memory controller busy; a word is accepted when iREN && !iwait.
- iload  input  32  refill data, valid when iREN && !iwait.
- busy  output  1  high in FILL or FLUSH.

Behaviour:
- Address split: [1:0] byte offset (ignored); next log2(BLOCK_WORDS) bits word offset; next log2(SETS) bits index; remaining upper bits tag.
- Storage per set per way: valid bit, tag, BLOCK_WORDS data words. Per set: one LRU bit (WAYS=2), naming the least recently used way.
- Reset (asynchronous) forces:
  - all valid bits 0, all LRU bits 0, FSM IDLE, refill counter 0, pending-flush 0;
  - outputs ihit=0, iREN=0, iaddr=0, busy=0, imemload=0.
  - Reset during FILL discards the partial block; no line becomes valid.
- FSM states IDLE, FILL, FLUSH.
- IDLE:
  - Hit is combinational: ihit = imemREN && state==IDLE && some way valid with matching tag at the index.
  - imemload = that way's word at the word offset; 0 when there is no hit.
  - On a hit clock edge (WAYS=2), the LRU bit is set to the other way.
  - imemREN && miss -> latch tag/index as the miss address and select a victim.
  - Victim: the lowest-numbered invalid way, else the LRU way (always way 0 when WAYS=1). Go to FILL, counter=0.
  - flush high in IDLE -> FLUSH (takes priority over a miss in the same cycle).
- FILL:
  - iREN=1; iaddr = {latched tag, latched index, counter, 2'b00}. Words are fetched in order 0..BLOCK_WORDS-1.
  - Each cycle with !iwait: write iload into victim word[counter], counter+1.
  - On acceptance of the last word: set victim valid and tag, set LRU to the non-victim way, go to IDLE.
  - ihit=0 throughout FILL. The first hit occurs the cycle after FILL exits (minimum miss latency BLOCK_WORDS+1 cycles with iwait=0).
  - Changes to imemaddr or imemREN during FILL do not affect the refill. On return to IDLE the current imemaddr is evaluated fresh.
  - flush during FILL sets pending-flush. On fill completion go to FLUSH instead of IDLE.
- FLUSH:
  - One cycle; clears every valid bit and LRU bit and the pending flag, then goes to IDLE.
  - ihit=0 and iREN=0.
- busy = (state != IDLE).
- The counter width is max(1, log2(BLOCK_WORDS)); it wraps to 0 on block completion.

Test Plan:
- Bench memory: word at byte address A = A ^ 32'hA5A50000; iwait=0 unless stated. Defaults SETS=8, BLOCK_WORDS=2, WAYS=2.
- Cold miss at 0x04:
  - iREN goes high for exactly 2 cycles with iaddr 0x00 then 0x04.
  - ihit=1 on the next cycle with imemload=0xA5A50004.
  - A later fetch of 0x00 hits immediately with 0xA5A50000.
- Two-way conflict:
  - Fill 0x000 (tag A) then 0x040 (tag B, same index 0); both then hit.
  - Read 0x000, then miss 0x080: way holding 0x040 is evicted.
  - 0x000 still hits; 0x040 misses.
- iwait stall: with iwait=1 for 3 cycles per word on a miss at 0x10:
  - iaddr holds 0x10 while stalled; fill completes in 8 cycles.
  - Word order is 0x10 then 0x14.
- Flush:
  - After filling 0x00 and 0x20, pulse flush: busy=1 for 1 cycle.
  - Both addresses then miss.
  - flush asserted mid-FILL: fill completes, then the FLUSH cycle, then the just-filled line misses.
- Reset mid-fill: assert RST after the first refill word. iREN drops immediately with no clock edge; after release, 0x00 misses again.
- Parametric: WAYS=1, BLOCK_WORDS=4, SETS=4.
  - Miss at 0x08 issues iaddr 0x00,0x04,0x08,0x0C.
  - 0x48 maps to index 0 and evicts the line.
